sensor_input_conditioner: RTL and testbench

- Input-side counterpart of the display/matrix output path: synchronises, debounces and validates the raw switch/sensor inputs before they reach the water, irrigation and alarm controllers.
- Produces clean sensor levels, the 2-bit water encoding, a persistence-filtered conflict flag, a one-cycle pulse strobe, and a valid/ack snapshot interface for downstream consumers.
- Sits between board pins and the controller logic; ticks on an enable derived from the existing clock divisor chain.

---
 rtl/sensor_input_conditioner_pkg.sv | 25 ++
 rtl/sensor_input_conditioner_debounce_cell.sv | 53 +++++
 rtl/sensor_input_conditioner.sv | 135 +++++++++++++
 tb/tb_sensor_input_conditioner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_input_conditioner_pkg.sv
// Shared constants for the sensor input conditioner: sensor bit positions,
// water level codes and the snapshot handshake states.
package sensor_input_conditioner_pkg;

    localparam int SENSOR_W = 6;

    // Bit positions inside raw_sensors / sensor_word.
    localparam int LOW_W   = 0;
    localparam int MID_W   = 1;
    localparam int HIGH_W  = 2;
    localparam int EARTH_H = 3;
    localparam int AIR_H   = 4;
    localparam int LOW_T   = 5;

    localparam logic [1:0] WATER_NONE = 2'b00;
    localparam logic [1:0] WATER_LOW  = 2'b01;
    localparam logic [1:0] WATER_MID  = 2'b10;
    localparam logic [1:0] WATER_HIGH = 2'b11;

    typedef enum logic {
        HS_IDLE    = 1'b0,
        HS_PRESENT = 1'b1
    } hs_state_e;

endpackage

// File: rtl/sensor_input_conditioner_debounce_cell.sv
// One input bit: two-flop synchroniser followed by a tick-counted debouncer.
// A new level is accepted only after DEBOUNCE_TICKS consecutive differing ticks.
module debounce_cell #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic sample_tick,
    input  logic raw,
    output logic clean
);

    localparam logic [3:0] LAST_COUNT = 4'(DEBOUNCE_TICKS - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       stable_q;
    logic       stable_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sample_tick) begin
            if (sync2_q == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == LAST_COUNT) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign clean = stable_q;

endmodule

// File: rtl/sensor_input_conditioner.sv
// Conditions raw board inputs: debounce, water level encoding with a
// persistence-filtered conflict flag, pulse strobe and a valid/ack snapshot.
module sensor_input_conditioner
    import sensor_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int CONFLICT_TICKS = 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                sample_tick,
    input  logic [SENSOR_W-1:0] raw_sensors,
    input  logic                raw_selector,
    input  logic                raw_pulse,
    output logic [SENSOR_W-1:0] sensor_word,
    output logic                selector_clean,
    output logic                pulse_strobe,
    output logic [1:0]          encoded_water,
    output logic                conflicting_values,
    output logic                sensor_valid,
    output logic [SENSOR_W-1:0] sensor_data,
    input  logic                sensor_ack
);

    localparam logic [3:0] CONFLICT_MAX = 4'(CONFLICT_TICKS);

    logic [SENSOR_W-1:0] clean_w;
    logic                selector_w;
    logic                pulse_w;

    for (genvar i = 0; i < SENSOR_W; i++) begin : g_sensor
        debounce_cell #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_cell (
            .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick),
            .raw(raw_sensors[i]), .clean(clean_w[i])
        );
    end

    debounce_cell #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_selector (
        .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick),
        .raw(raw_selector), .clean(selector_w)
    );

    debounce_cell #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_pulse (
        .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick),
        .raw(raw_pulse), .clean(pulse_w)
    );

    logic                inconsistent;
    logic [1:0]          water_code;
    logic [1:0]          water_q;
    logic [3:0]          conf_cnt_q;
    logic [3:0]          conf_cnt_d;
    logic                pulse_prev_q;
    logic                strobe_q;
    hs_state_e           state_q;
    hs_state_e           state_d;
    logic                valid_q;
    logic                valid_d;
    logic [SENSOR_W-1:0] data_q;
    logic [SENSOR_W-1:0] data_d;

    assign inconsistent = (clean_w[MID_W]  & ~clean_w[LOW_W]) |
                          (clean_w[HIGH_W] & ~clean_w[MID_W]);

    // Only meaningful while consistent; higher levels imply the lower ones.
    always_comb begin
        water_code = WATER_NONE;
        if (clean_w[HIGH_W])      water_code = WATER_HIGH;
        else if (clean_w[MID_W])  water_code = WATER_MID;
        else if (clean_w[LOW_W])  water_code = WATER_LOW;
    end

    always_comb begin
        conf_cnt_d = conf_cnt_q;
        if (!inconsistent) begin
            conf_cnt_d = '0;
        end else if (sample_tick && (conf_cnt_q < CONFLICT_MAX)) begin
            conf_cnt_d = conf_cnt_q + 4'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        unique case (state_q)
            HS_IDLE: begin
                if (clean_w != data_q) begin
                    data_d  = clean_w;
                    valid_d = 1'b1;
                    state_d = HS_PRESENT;
                end
            end
            HS_PRESENT: begin
                if (sensor_ack) begin
                    valid_d = 1'b0;
                    state_d = HS_IDLE;
                end
            end
            default: begin
                state_d = HS_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            water_q      <= WATER_NONE;
            conf_cnt_q   <= '0;
            pulse_prev_q <= 1'b0;
            strobe_q     <= 1'b0;
            state_q      <= HS_IDLE;
            valid_q      <= 1'b0;
            data_q       <= '0;
        end else begin
            if (!inconsistent) water_q <= water_code;
            conf_cnt_q   <= conf_cnt_d;
            pulse_prev_q <= pulse_w;
            strobe_q     <= pulse_w & ~pulse_prev_q;
            state_q      <= state_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
        end
    end

    assign sensor_word        = clean_w;
    assign selector_clean     = selector_w;
    assign pulse_strobe       = strobe_q;
    assign encoded_water      = water_q;
    assign conflicting_values = (conf_cnt_q == CONFLICT_MAX);
    assign sensor_valid       = valid_q;
    assign sensor_data        = data_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Directed bench for sensor_input_conditioner; snapshot presentations are
// checked by a queue-based monitor, levels and flags by direct checks.
module tb_sensor_input_conditioner;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       sample_tick;
    logic [5:0] raw_sensors;
    logic       raw_selector;
    logic       raw_pulse;
    logic       sensor_ack;
    logic [5:0] sensor_word;
    logic       selector_clean;
    logic       pulse_strobe;
    logic [1:0] encoded_water;
    logic       conflicting_values;
    logic       sensor_valid;
    logic [5:0] sensor_data;

    int         checks = 0;
    int         errors = 0;
    int         strobeCount = 0;
    logic [5:0] expQ[$];
    logic       prevValid = 1'b0;
    logic       prevStrobe = 1'b0;

    sensor_input_conditioner dut (
        .clock(clock), .reset_n(reset_n), .sample_tick(sample_tick),
        .raw_sensors(raw_sensors), .raw_selector(raw_selector), .raw_pulse(raw_pulse),
        .sensor_word(sensor_word), .selector_clean(selector_clean),
        .pulse_strobe(pulse_strobe), .encoded_water(encoded_water),
        .conflicting_values(conflicting_values), .sensor_valid(sensor_valid),
        .sensor_data(sensor_data), .sensor_ack(sensor_ack)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic [5:0] s, input logic sel, input logic pb);
        raw_sensors  = s;
        raw_selector = sel;
        raw_pulse    = pb;
    endtask

    task automatic ackOnce();
        sensor_ack = 1'b1;
        waitClocks(1);
        sensor_ack = 1'b0;
    endtask

    // Each new presentation must match the oldest expected snapshot.
    always @(negedge clock) begin
        if (sensor_valid && !prevValid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL presentUnexpected: actual=%0h required=none", sensor_data);
            end else begin
                checkOutput("presentData", 8'(sensor_data), 8'(expQ.pop_front()));
            end
        end
        if (pulse_strobe) begin
            if (prevStrobe) begin
                checks++;
                errors++;
                $display("[TB] FAIL strobeWidth: actual=2+ clocks required=1 clock");
            end else begin
                strobeCount++;
            end
        end
        prevValid  = sensor_valid;
        prevStrobe = pulse_strobe;
    end

    initial begin
        reset_n     = 1'b0;
        sample_tick = 1'b1;
        sensor_ack  = 1'b0;
        applyStimulus(6'b000000, 1'b0, 1'b0);
        waitClocks(3);
        checkOutput("resetWord", 8'(sensor_word), 8'h00);
        checkOutput("resetValid", 8'(sensor_valid), 8'h00);
        checkOutput("resetData", 8'(sensor_data), 8'h00);
        checkOutput("resetWater", 8'(encoded_water), 8'h00);
        checkOutput("resetConflict", 8'(conflicting_values), 8'h00);
        checkOutput("resetStrobe", 8'(pulse_strobe), 8'h00);
        reset_n = 1'b1;

        // First accepted word: 2 sync clocks + 4 debounce ticks.
        expQ.push_back(6'b000001);
        applyStimulus(6'b000001, 1'b0, 1'b0);
        waitClocks(5);
        checkOutput("debounceEarly", 8'(sensor_word), 8'h00);
        waitClocks(1);
        checkOutput("debounceAccept", 8'(sensor_word), 8'h01);
        checkOutput("validLatency", 8'(sensor_valid), 8'h00);
        waitClocks(1);
        checkOutput("firstValid", 8'(sensor_valid), 8'h01);
        checkOutput("waterLow", 8'(encoded_water), 8'h01);
        ackOnce();
        checkOutput("ackDrop", 8'(sensor_valid), 8'h00);
        waitClocks(4);
        checkOutput("noRepresent", 8'(sensor_valid), 8'h00);

        // Three-tick glitch on high_water_level must be rejected.
        applyStimulus(6'b000101, 1'b0, 1'b0);
        waitClocks(3);
        applyStimulus(6'b000001, 1'b0, 1'b0);
        waitClocks(8);
        checkOutput("glitchWord", 8'(sensor_word), 8'h01);
        checkOutput("glitchValid", 8'(sensor_valid), 8'h00);

        // Water path: low+mid, then inconsistent high-only, then all three.
        expQ.push_back(6'b000011);
        applyStimulus(6'b000011, 1'b0, 1'b0);
        waitClocks(7);
        checkOutput("waterMid", 8'(encoded_water), 8'h02);
        checkOutput("midNoConflict", 8'(conflicting_values), 8'h00);
        ackOnce();

        expQ.push_back(6'b000100);
        applyStimulus(6'b000100, 1'b0, 1'b0);
        waitClocks(6);
        checkOutput("highOnlyWord", 8'(sensor_word), 8'h04);
        checkOutput("conflictAtAccept", 8'(conflicting_values), 8'h00);
        waitClocks(2);
        checkOutput("conflictTwoTicks", 8'(conflicting_values), 8'h00);
        waitClocks(1);
        checkOutput("conflictThreeTicks", 8'(conflicting_values), 8'h01);
        checkOutput("waterHold", 8'(encoded_water), 8'h02);
        ackOnce();

        expQ.push_back(6'b000111);
        applyStimulus(6'b000111, 1'b0, 1'b0);
        waitClocks(6);
        checkOutput("allWord", 8'(sensor_word), 8'h07);
        checkOutput("conflictStillSet", 8'(conflicting_values), 8'h01);
        waitClocks(1);
        checkOutput("conflictCleared", 8'(conflicting_values), 8'h00);
        checkOutput("waterHigh", 8'(encoded_water), 8'h03);
        ackOnce();

        // Button held long gives one strobe; selector debounces alongside.
        applyStimulus(6'b000111, 1'b1, 1'b1);
        waitClocks(5);
        checkOutput("selectorEarly", 8'(selector_clean), 8'h00);
        waitClocks(1);
        checkOutput("selectorAccept", 8'(selector_clean), 8'h01);
        waitClocks(14);
        checkOutput("strobeOnce", 8'(strobeCount), 8'd1);
        applyStimulus(6'b000111, 1'b1, 1'b0);
        waitClocks(10);
        checkOutput("noReleaseStrobe", 8'(strobeCount), 8'd1);
        applyStimulus(6'b000111, 1'b1, 1'b1);
        waitClocks(10);
        checkOutput("secondStrobe", 8'(strobeCount), 8'd2);
        applyStimulus(6'b000111, 1'b1, 1'b0);
        waitClocks(10);

        // Backpressure: snapshot frozen until ack, then the newer word follows.
        expQ.push_back(6'b000001);
        applyStimulus(6'b000001, 1'b1, 1'b0);
        waitClocks(7);
        checkOutput("bpPresent", 8'(sensor_valid), 8'h01);
        expQ.push_back(6'b000011);
        applyStimulus(6'b000011, 1'b1, 1'b0);
        waitClocks(7);
        checkOutput("bpWordMoved", 8'(sensor_word), 8'h03);
        checkOutput("bpFrozen", 8'(sensor_data), 8'h01);
        checkOutput("bpHeld", 8'(sensor_valid), 8'h01);
        ackOnce();
        checkOutput("bpGap", 8'(sensor_valid), 8'h00);
        waitClocks(1);
        checkOutput("bpNextValid", 8'(sensor_valid), 8'h01);
        checkOutput("bpNextData", 8'(sensor_data), 8'h03);
        ackOnce();

        // Reset while presenting and with a debounce count at 3.
        expQ.push_back(6'b000111);
        applyStimulus(6'b000111, 1'b1, 1'b0);
        waitClocks(7);
        checkOutput("preResetValid", 8'(sensor_valid), 8'h01);
        applyStimulus(6'b000011, 1'b1, 1'b0);
        waitClocks(5);
        reset_n = 1'b0;
        #1;
        checkOutput("midResetWord", 8'(sensor_word), 8'h00);
        checkOutput("midResetValid", 8'(sensor_valid), 8'h00);
        checkOutput("midResetData", 8'(sensor_data), 8'h00);
        checkOutput("midResetSelector", 8'(selector_clean), 8'h00);
        checkOutput("midResetWater", 8'(encoded_water), 8'h00);
        checkOutput("midResetStrobe", 8'(pulse_strobe), 8'h00);
        applyStimulus(6'b000000, 1'b0, 1'b0);
        waitClocks(3);
        reset_n = 1'b1;
        waitClocks(15);
        checkOutput("postResetNoValid", 8'(sensor_valid), 8'h00);
        checkOutput("postResetWord", 8'(sensor_word), 8'h00);
        checkOutput("postResetNoStrobe", 8'(strobeCount), 8'd2);

        expQ.push_back(6'b000001);
        applyStimulus(6'b000001, 1'b0, 1'b0);
        waitClocks(7);
        checkOutput("postResetPresent", 8'(sensor_valid), 8'h01);
        ackOnce();
        waitClocks(3);
        checkOutput("queueDrained", 8'(expQ.size()), 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
